// File: rtl/mdio_pkg.sv
// Shared MDIO master definitions: FSM states, ST/OP encodings and frame layout.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  // Start-of-frame codes
  localparam logic [1:0] ST_C22   = 2'b01;
  localparam logic [1:0] ST_C45   = 2'b00;

  // Opcodes
  localparam logic [1:0] C22_RD   = 2'b10;
  localparam logic [1:0] C22_WR   = 2'b01;
  localparam logic [1:0] C45_ADDR = 2'b00;
  localparam logic [1:0] C45_WR   = 2'b01;
  localparam logic [1:0] C45_RD   = 2'b11;
  localparam logic [1:0] C45_PRIA = 2'b10;

  // Frame field offsets within T_DATA
  localparam int unsigned ST_MSB     = 31;
  localparam int unsigned ST_LSB     = 30;
  localparam int unsigned OP_MSB     = 29;
  localparam int unsigned OP_LSB     = 28;
  localparam int unsigned HDR_BITS   = 14;
  localparam int unsigned TA_BITS    = 2;
  localparam int unsigned FRAME_BITS = 32;

  // A frame is legal when its ST/OP pair names a defined Clause 22 or 45 operation.
  function automatic logic op_legal(input logic [1:0] st, input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_C22:  ok = (op == C22_RD) || (op == C22_WR);
      ST_C45:  ok = (op == C45_ADDR) || (op == C45_WR) || (op == C45_RD) || (op == C45_PRIA);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC generator: half-period of DIV clk cycles, low whenever disabled, with
// strobes marking the clk edge on which MDC is about to rise or fall.
module mdc_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             mdc_q;
  logic             tick;

  assign tick     = en && (cnt == CNT_LAST);
  assign mdc_rise = tick & ~mdc_q;
  assign mdc_fall = tick &  mdc_q;
  assign mdc      = mdc_q;

  // Half-period counter and MDC toggle; restarts from low phase on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mdc_q <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      mdc_q <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// MDIO management master: serialises preamble plus a 32-bit Clause 22/45
// frame onto MDC/MDIO, captures read data and flags TA/opcode errors.
module mdio_master #(
  parameter int unsigned DIV     = 1,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        ERR
);

  import mdio_pkg::*;

  localparam int unsigned CW = $clog2(PRE_LEN + 33);
  // Bit index of the last bit in each phase, counted from the first preamble bit
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_LEN == 0) ? 0 : PRE_LEN - 1);
  localparam logic [CW-1:0] HDR_LAST  = CW'(PRE_LEN + HDR_BITS - 1);
  localparam logic [CW-1:0] TA_LAST   = CW'(PRE_LEN + HDR_BITS + TA_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(PRE_LEN + FRAME_BITS - 1);

  state_t          state, state_nxt;
  logic            start_q;
  logic            launch;
  logic            legal;
  logic            mdc_en;
  logic            mdc_rise;
  logic            mdc_fall;
  logic [CW-1:0]   bit_cnt;
  logic [31:0]     tx_sr;
  logic            is_read;
  logic            err_q;
  logic [15:0]     rd_q;

  assign launch  = (state == S_IDLE) && MDIO_START && !start_q;
  assign legal   = op_legal(T_DATA[ST_MSB:ST_LSB], T_DATA[OP_MSB:OP_LSB]);
  assign RD_DATA = rd_q;
  assign ERR     = err_q;

  mdc_gen #(
    .DIV (DIV)
  ) u_mdc_gen (
    .clk      (clk),
    .rst_n    (rst),
    .en       (mdc_en),
    .mdc      (MDC),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and pad/handshake outputs; phases advance on MDC falling edges
  always_comb begin
    state_nxt = state;
    mdc_en    = 1'b0;
    MDIO_OE   = 1'b0;
    MDIO_OUT  = 1'b0;
    DATA_RDY  = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) begin
          if (!legal)            state_nxt = S_DONE;
          else if (PRE_LEN == 0) state_nxt = S_HDR;
          else                   state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        mdc_en   = 1'b1;
        MDIO_OE  = 1'b1;
        MDIO_OUT = 1'b1;
        if (mdc_fall && bit_cnt == PRE_LAST) state_nxt = S_HDR;
      end
      S_HDR: begin
        mdc_en   = 1'b1;
        MDIO_OE  = 1'b1;
        MDIO_OUT = tx_sr[31];
        if (mdc_fall && bit_cnt == HDR_LAST) state_nxt = S_TA;
      end
      S_TA: begin
        mdc_en   = 1'b1;
        MDIO_OE  = !is_read;
        MDIO_OUT = !is_read & tx_sr[31];
        if (mdc_fall && bit_cnt == TA_LAST) state_nxt = S_DATA;
      end
      S_DATA: begin
        mdc_en   = 1'b1;
        MDIO_OE  = !is_read;
        MDIO_OUT = !is_read & tx_sr[31];
        if (mdc_fall && bit_cnt == DATA_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        DATA_RDY  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, bit counting, TA check and read-data shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      tx_sr   <= '0;
      bit_cnt <= '0;
      is_read <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      start_q <= MDIO_START;
      if (launch) begin
        tx_sr   <= T_DATA;
        bit_cnt <= '0;
        is_read <= legal & T_DATA[OP_MSB];
        err_q   <= !legal;
      end else begin
        if (mdc_rise && is_read) begin
          if (state == S_TA && bit_cnt == TA_LAST && MDIO_IN) err_q <= 1'b1;
          if (state == S_DATA) rd_q <= {rd_q[14:0], MDIO_IN};
        end
        if (mdc_fall) begin
          bit_cnt <= bit_cnt + CW'(1);
          // preamble bits are constant 1, so the frame shifter holds until HDR
          if (state != S_PRE) tx_sr <= {tx_sr[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: two instances (DIV=1/PRE_LEN=32 and
// DIV=3/PRE_LEN=0), per-bit pad checks and queued completion checks.
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [31:0] t_data = '0;
  logic        mdio_in = 1'b1;

  logic        mdc1, out1, oe1, rdy1, err1;
  logic [15:0] rd1;
  logic        mdc3, out3, oe3, rdy3, err3;
  logic [15:0] rd3;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    bit          sel;
    int unsigned cyc;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_rd1 = '0;
  logic [15:0] last_rd3 = '0;

  mdio_master u_dut (
    .clk        (clk),
    .rst        (rst),
    .MDIO_START (start1),
    .T_DATA     (t_data),
    .MDIO_IN    (mdio_in),
    .MDC        (mdc1),
    .MDIO_OUT   (out1),
    .MDIO_OE    (oe1),
    .RD_DATA    (rd1),
    .DATA_RDY   (rdy1),
    .ERR        (err1)
  );

  mdio_master #(
    .DIV     (3),
    .PRE_LEN (0)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .MDIO_START (start3),
    .T_DATA     (t_data),
    .MDIO_IN    (mdio_in),
    .MDC        (mdc3),
    .MDIO_OUT   (out3),
    .MDIO_OE    (oe3),
    .RD_DATA    (rd3),
    .DATA_RDY   (rdy3),
    .ERR        (err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bench_legal(input logic [31:0] d);
    logic [1:0] st;
    logic [1:0] op;
    st = d[31:30];
    op = d[29:28];
    if (st == 2'b00) return 1'b1;
    if (st == 2'b01) return (op == 2'b01) || (op == 2'b10);
    return 1'b0;
  endfunction

  // Completion monitor: every DATA_RDY pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst && (rdy1 || rdy3)) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", {30'd0, rdy3, rdy1}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdy_dut", {31'd0, rdy3}, {31'd0, e.sel});
        check("rdy_cycle", cyc, e.cyc);
        check("err", {31'd0, e.sel ? err3 : err1}, {31'd0, e.err});
        check("rd_data", {16'd0, e.sel ? rd3 : rd1}, {16'd0, e.rd});
      end
    end
  end

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run_frame(input bit sel, input logic [31:0] tdata,
                           input logic [15:0] rd_word, input logic ta2, input bit hold);
    int unsigned div, pre, n, c0, tb, limit, relaunch;
    bit          legal, is_read, oe_exp;
    exp_t        e;
    div     = sel ? 3 : 1;
    pre     = sel ? 0 : 32;
    n       = pre + 32;
    legal   = bench_legal(tdata);
    is_read = legal && tdata[29];
    e.sel   = sel;
    e.err   = !legal || (is_read && ta2);
    if (is_read) begin
      if (sel) last_rd3 = rd_word;
      else     last_rd1 = rd_word;
    end
    e.rd = sel ? last_rd3 : last_rd1;

    @(posedge clk);
    #1;
    t_data = tdata;
    c0     = cyc;
    e.cyc  = c0 + 1 + (legal ? 2 * div * n : 0);
    sb.push_back(e);
    if (sel) start3 = 1'b1;
    else     start1 = 1'b1;

    if (legal) begin
      for (int unsigned k = 0; k < n; k++) begin
        tb = c0 + 1 + 2 * div * k;
        wait_cyc(tb);
        oe_exp = !is_read || (k < pre + 14);
        check("mdc_low", {31'd0, sel ? mdc3 : mdc1}, 32'd0);
        check("oe", {31'd0, sel ? oe3 : oe1}, {31'd0, oe_exp});
        if (oe_exp)
          check("mdio_out", {31'd0, sel ? out3 : out1},
                {31'd0, (k < pre) ? 1'b1 : tdata[31 - (k - pre)]});
        if (is_read && k >= pre + 14) begin
          if (k == pre + 14)      mdio_in = 1'b1;
          else if (k == pre + 15) mdio_in = ta2;
          else                    mdio_in = rd_word[15 - (k - pre - 16)];
        end
        wait_cyc(tb + div);
        check("mdc_high", {31'd0, sel ? mdc3 : mdc1}, 32'd1);
      end
    end else begin
      for (int unsigned j = 1; j <= 4; j++) begin
        wait_cyc(c0 + j);
        check("illegal_mdc", {31'd0, sel ? mdc3 : mdc1}, 32'd0);
      end
    end

    limit = e.cyc + 4;
    while (sb.size() != 0 && cyc < limit) @(negedge clk);
    if (sb.size() != 0) begin
      check("rdy_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    mdio_in = 1'b1;

    if (hold) begin
      relaunch = 0;
      repeat (40) begin
        @(negedge clk);
        if (mdc1 || mdc3 || oe1 || oe3) relaunch++;
      end
      check("relaunch", relaunch, 32'd0);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mdc",  {31'd0, mdc1}, 32'd0);
    check("rst_out",  {31'd0, out1}, 32'd0);
    check("rst_oe",   {31'd0, oe1},  32'd0);
    check("rst_rd",   {16'd0, rd1},  32'd0);
    check("rst_rdy",  {31'd0, rdy1}, 32'd0);
    check("rst_err",  {31'd0, err1}, 32'd0);
    check("rst_mdc3", {31'd0, mdc3}, 32'd0);
    check("rst_rdy3", {31'd0, rdy3}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 32'h5A5AFF01, 16'h0000, 1'b0, 1'b0);  // C22 write
    run_frame(1'b0, 32'h68820000, 16'h8FF1, 1'b0, 1'b0);  // C22 read
    run_frame(1'b0, 32'h68820000, 16'hFFFF, 1'b1, 1'b0);  // read, no PHY answer
    run_frame(1'b0, 32'h7A5AFF01, 16'h0000, 1'b0, 1'b0);  // illegal opcode
    run_frame(1'b1, 32'h0002ABCD, 16'h0000, 1'b0, 1'b0);  // C45 address, DIV=3
    run_frame(1'b1, 32'h3C020000, 16'h1234, 1'b0, 1'b0);  // C45 read, DIV=3

    // Abort a write mid-frame while MDC is high at bit 20
    @(posedge clk);
    #1;
    t_data = 32'h5A5AFF01;
    c0     = cyc;
    start1 = 1'b1;
    wait_cyc(c0 + 1 + 2 * 20 + 1);
    check("abort_pre_mdc", {31'd0, mdc1}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_mdc", {31'd0, mdc1}, 32'd0);
    check("abort_oe",  {31'd0, oe1},  32'd0);
    check("abort_rdy", {31'd0, rdy1}, 32'd0);
    check("abort_rd",  {16'd0, rd1},  32'd0);
    last_rd1 = '0;
    last_rd3 = '0;
    start1   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 32'h5A5AFF01, 16'h0000, 1'b0, 1'b1);  // recovery + held START

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
